// File: rtl/scarv_cop_rng_pkg.sv
// scarv_cop_rng_pkg: LFSR taps, RTEST status layout, FSM encoding and RANDOM instruction codes.
package scarv_cop_rng_pkg;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
  localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;
  localparam int RT_OK    = 0;
  localparam int RT_FULL  = 1;
  localparam int RT_EMPTY = 2;
  localparam int RT_LEVEL = 8;
  localparam logic [3:0] ICLASS_RANDOM   = 4'b0100;
  localparam logic [4:0] SUBCLASS_RSEED  = 5'b00001;
  localparam logic [4:0] SUBCLASS_RSAMP  = 5'b00010;
  localparam logic [4:0] SUBCLASS_RTEST  = 5'b00100;
  typedef enum logic {ST_IDLE, ST_WAIT} rng_state_t;
  function automatic logic [63:0] lfsr_taps(input int w);
    return w == 64 ? LFSR_TAPS_64 : {32'h0, LFSR_TAPS_32};
  endfunction
endpackage

// File: rtl/scarv_cop_rng_fifo.sv
// scarv_cop_rng_fifo: 32-bit synchronous FIFO holding pre-generated random words; flush empties it.
module scarv_cop_rng_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     g_clk,
  input  logic                     g_resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] lvl_q, lvl_d;
  always_comb begin
    rd_d  = flush ? '0 : rd_q + AW'(pop);
    wr_d  = flush ? '0 : wr_q + AW'(push);
    lvl_d = flush ? '0 : lvl_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      rd_q  <= '0;
      wr_q  <= '0;
      lvl_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      lvl_q <= lvl_d;
    end
  end
  always_ff @(posedge g_clk) begin
    if (push && !flush) mem_q[wr_q] <= wdata;
  end
  assign rdata = mem_q[rd_q];
  assign full  = lvl_q == (AW+1)'(DEPTH);
  assign empty = lvl_q == '0;
  assign level = lvl_q;
endmodule

// File: rtl/scarv_cop_rng_pool.sv
// scarv_cop_rng_pool: Fibonacci LFSR feeding a word pool so RSAMP usually completes in one cycle,
// with a sticky repetition health test reported through RTEST.
module scarv_cop_rng_pool
  import scarv_cop_rng_pkg::*;
#(
  parameter int          LFSR_W          = 32,
  parameter int          POOL_DEPTH      = 4,
  parameter int          STEPS_PER_WORD  = 1,
  parameter logic [63:0] RNG_RESET_VALUE = 64'd1,
  parameter int          REPEAT_LIMIT    = 3
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        rng_ivalid,
  output logic        rng_idone,
  input  logic [31:0] rng_rs1,
  input  logic [3:0]  id_class,
  input  logic [4:0]  id_subclass,
  output logic [3:0]  rng_cpr_rd_ben,
  output logic [31:0] rng_cpr_rd_wdata,
  output logic [31:0] cop_random,
  output logic        cop_rand_sample
);
  localparam int LW = $clog2(POOL_DEPTH);
  localparam logic [LFSR_W-1:0] TAPS    = LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [LFSR_W-1:0] RST_RAW = LFSR_W'(RNG_RESET_VALUE);
  localparam logic [LFSR_W-1:0] RST_V   = RST_RAW == '0 ? LFSR_W'(1) : RST_RAW;
  rng_state_t state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_nxt, seed;
  logic [3:0] step_q, step_d, rep_q, rep_d, rep_nxt;
  logic fail_q, fail_d;
  logic [31:0] prev_q, prev_d, head, status;
  logic is_rng, is_seed, is_samp, is_test, samp_done, gen, last_step, push, pop, full, empty;
  logic [LW:0] level;
  assign is_rng    = rng_ivalid && id_class == ICLASS_RANDOM;
  assign is_seed   = is_rng && id_subclass == SUBCLASS_RSEED;
  assign is_samp   = is_rng && id_subclass == SUBCLASS_RSAMP;
  assign is_test   = is_rng && id_subclass == SUBCLASS_RTEST;
  assign seed      = LFSR_W == 64 ? LFSR_W'({~rng_rs1, rng_rs1}) : LFSR_W'(rng_rs1);
  assign lfsr_nxt  = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
  assign gen       = !full && !fail_q && !is_seed;
  assign last_step = step_q == 4'(STEPS_PER_WORD - 1);
  assign push      = gen && last_step;
  // No bypass: a waiting RSAMP only sees words already registered in the pool.
  assign samp_done = is_samp && (fail_q || (state_q == ST_WAIT ? level != '0 : !empty));
  assign pop       = samp_done && !fail_q;
  always_comb begin
    rep_nxt = rep_q != '0 && lfsr_nxt[31:0] == prev_q ? rep_q + 4'd1 : 4'd1;
    lfsr_d  = is_seed ? (seed == '0 ? LFSR_W'(1) : seed) : gen ? lfsr_nxt : lfsr_q;
    step_d  = is_seed ? '0 : gen ? (last_step ? '0 : step_q + 4'd1) : step_q;
    rep_d   = is_seed ? '0 : push ? rep_nxt : rep_q;
    fail_d  = !is_seed && (fail_q || (push && rep_nxt == 4'(REPEAT_LIMIT)));
    prev_d  = push ? lfsr_nxt[31:0] : prev_q;
    state_d = is_samp && !samp_done ? ST_WAIT : ST_IDLE;
  end
  always_comb begin
    status                 = '0;
    status[RT_OK]          = !fail_q;
    status[RT_FULL]        = full;
    status[RT_EMPTY]       = empty;
    status[RT_LEVEL +: 8]  = 8'(level);
    rng_idone              = is_seed || is_test || samp_done;
    rng_cpr_rd_ben         = samp_done ? 4'hF : 4'h0;
    rng_cpr_rd_wdata       = pop ? head : is_test ? status : '0;
    cop_random             = pop ? head : '0;
    cop_rand_sample        = samp_done;
  end
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      lfsr_q  <= RST_V;
      step_q  <= '0;
      rep_q   <= '0;
      fail_q  <= 1'b0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      step_q  <= step_d;
      rep_q   <= rep_d;
      fail_q  <= fail_d;
      prev_q  <= prev_d;
    end
  end
  scarv_cop_rng_fifo #(.DEPTH(POOL_DEPTH)) u_fifo (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .flush    (is_seed),
    .push     (push),
    .pop      (pop),
    .wdata    (lfsr_nxt[31:0]),
    .rdata    (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );
endmodule

// File: tb/tb_scarv_cop_rng_pool.sv
// tb_scarv_cop_rng_pool: directed checks of three pool configurations sharing one clock and reset.
module tb_scarv_cop_rng_pool;
  import scarv_cop_rng_pkg::*;
  logic clk = 1'b0, rstn = 1'b0;
  logic [31:0] rs1 = '0;
  logic [3:0] cls = '0;
  logic [4:0] sub = '0;
  logic iv_a = 1'b0, iv_b = 1'b0, iv_c = 1'b0;
  logic done_a, done_b, done_c, smp_a, smp_b, smp_c;
  logic [3:0] ben_a, ben_b, ben_c;
  logic [31:0] wd_a, wd_b, wd_c, rnd_a, rnd_b, rnd_c;
  logic [31:0] b2b [4];
  int n_tests = 0, n_fail = 0, cnt = 0;
  always #5 clk = ~clk;
  scarv_cop_rng_pool #(.LFSR_W(32), .POOL_DEPTH(4), .STEPS_PER_WORD(1), .RNG_RESET_VALUE(64'd1), .REPEAT_LIMIT(3)) u_a (
    .g_clk(clk), .g_resetn(rstn), .rng_ivalid(iv_a), .rng_idone(done_a), .rng_rs1(rs1),
    .id_class(cls), .id_subclass(sub), .rng_cpr_rd_ben(ben_a), .rng_cpr_rd_wdata(wd_a),
    .cop_random(rnd_a), .cop_rand_sample(smp_a));
  scarv_cop_rng_pool #(.LFSR_W(32), .POOL_DEPTH(4), .STEPS_PER_WORD(4), .RNG_RESET_VALUE(64'd1), .REPEAT_LIMIT(3)) u_b (
    .g_clk(clk), .g_resetn(rstn), .rng_ivalid(iv_b), .rng_idone(done_b), .rng_rs1(rs1),
    .id_class(cls), .id_subclass(sub), .rng_cpr_rd_ben(ben_b), .rng_cpr_rd_wdata(wd_b),
    .cop_random(rnd_b), .cop_rand_sample(smp_b));
  scarv_cop_rng_pool #(.LFSR_W(64), .POOL_DEPTH(4), .STEPS_PER_WORD(1), .RNG_RESET_VALUE(64'd1), .REPEAT_LIMIT(3)) u_c (
    .g_clk(clk), .g_resetn(rstn), .rng_ivalid(iv_c), .rng_idone(done_c), .rng_rs1(rs1),
    .id_class(cls), .id_subclass(sub), .rng_cpr_rd_ben(ben_c), .rng_cpr_rd_wdata(wd_c),
    .cop_random(rnd_c), .cop_rand_sample(smp_c));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic samp();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    b2b = '{32'h6, 32'hD, 32'h1B, 32'h36};
    cls = ICLASS_RANDOM;
    repeat (2) tick();
    sub = SUBCLASS_RTEST;
    iv_b = 1'b1;
    samp();
    chk("rst_status_b", wd_b, 32'h5);
    chk("rst_done_b", done_b, 1);
    chk("rst_ben_b", ben_b, 0);
    chk("idle_done_a", done_a, 0);
    chk("idle_wdata_a", wd_a, 0);
    chk("idle_sample_a", smp_a, 0);
    tick();
    iv_b = 1'b0;
    rstn = 1'b1;
    repeat (6) tick();
    iv_a = 1'b1;
    samp();
    chk("t1_status", wd_a, 32'h0000_0403);
    chk("t1_done", done_a, 1);
    chk("t1_ben", ben_a, 0);
    tick();
    sub = SUBCLASS_RSAMP;
    samp();
    chk("t1_samp_done", done_a, 1);
    chk("t1_samp_ben", ben_a, 4'hF);
    chk("t1_samp_wdata", wd_a, 32'h3);
    chk("t1_cop_random", rnd_a, 32'h3);
    chk("t1_rand_sample", smp_a, 1);
    tick();
    iv_a = 1'b0;
    repeat (3) tick();
    cls = 4'h1;
    iv_a = 1'b1;
    samp();
    chk("other_class_done", done_a, 0);
    chk("other_class_wdata", wd_a, 0);
    chk("other_class_ben", ben_a, 0);
    tick();
    cls = ICLASS_RANDOM;
    for (int i = 0; i < 4; i++) begin
      samp();
      chk("t3_b2b_done", done_a, 1);
      chk("t3_b2b_wdata", wd_a, b2b[i]);
      tick();
    end
    sub = SUBCLASS_RSEED;
    rs1 = 32'h0;
    samp();
    chk("t2_seed_done", done_a, 1);
    chk("t2_seed_ben", ben_a, 0);
    chk("t2_seed_wdata", wd_a, 0);
    tick();
    sub = SUBCLASS_RSAMP;
    samp();
    chk("t2_stall", done_a, 0);
    tick();
    samp();
    chk("t2_done", done_a, 1);
    chk("t2_wdata", wd_a, 32'h3);
    tick();
    iv_a = 1'b0;
    sub = SUBCLASS_RSEED;
    iv_b = 1'b1;
    samp();
    chk("t4_seed_done", done_b, 1);
    tick();
    sub = SUBCLASS_RSAMP;
    cnt = 1;
    samp();
    while (done_b !== 1'b1 && cnt < 20) begin
      tick();
      samp();
      cnt++;
    end
    chk("t4_latency", cnt, 5);
    chk("t4_wdata", wd_b, 32'h1B);
    chk("t4_cop_random", rnd_b, 32'h1B);
    chk("t4_rand_sample", smp_b, 1);
    tick();
    iv_b = 1'b0;
    sub = SUBCLASS_RSEED;
    iv_c = 1'b1;
    samp();
    chk("t5_seed_done", done_c, 1);
    tick();
    iv_c = 1'b0;
    repeat (5) tick();
    sub = SUBCLASS_RTEST;
    iv_c = 1'b1;
    samp();
    chk("t5_fail_status", wd_c, 32'h0000_0300);
    tick();
    sub = SUBCLASS_RSAMP;
    samp();
    chk("t5_fail_done", done_c, 1);
    chk("t5_fail_ben", ben_c, 4'hF);
    chk("t5_fail_wdata", wd_c, 0);
    tick();
    sub = SUBCLASS_RTEST;
    samp();
    chk("t5_no_pop_status", wd_c, 32'h0000_0300);
    tick();
    sub = SUBCLASS_RSEED;
    rs1 = 32'hA5A5_0001;
    samp();
    chk("t5_reseed_done", done_c, 1);
    tick();
    sub = SUBCLASS_RTEST;
    samp();
    chk("t5_cleared_status", wd_c, 32'h5);
    tick();
    sub = SUBCLASS_RSAMP;
    samp();
    chk("t5_samp_done", done_c, 1);
    chk("t5_samp_wdata", wd_c, 32'h4B4A_0003);
    tick();
    iv_c = 1'b0;
    sub = SUBCLASS_RSEED;
    rs1 = 32'h0;
    iv_b = 1'b1;
    tick();
    sub = SUBCLASS_RSAMP;
    samp();
    chk("t6_wait0", done_b, 0);
    tick();
    samp();
    chk("t6_wait1", done_b, 0);
    rstn = 1'b0;
    tick();
    samp();
    chk("t6_rst_done", done_b, 0);
    sub = SUBCLASS_RTEST;
    iv_c = 1'b1;
    #1;
    chk("t6_rst_status_b", wd_b, 32'h5);
    chk("t6_rst_status_c", wd_c, 32'h5);
    tick();
    rstn = 1'b1;
    iv_c = 1'b0;
    sub = SUBCLASS_RSAMP;
    cnt = 1;
    samp();
    while (done_b !== 1'b1 && cnt < 20) begin
      tick();
      samp();
      cnt++;
    end
    chk("t6_post_latency", cnt, 5);
    chk("t6_post_wdata", wd_b, 32'h1B);
    tick();
    iv_b = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
